// File: rtl/crc32_pkg.sv
// crc32_pkg: CRC-32 constants and rx checker state type shared by rx/tx MAC stages
package crc32_pkg;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
  localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE        = 8'hD5;
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} crc_chk_state_t;
endpackage

// File: rtl/gmii_if.sv
// gmii_if: GMII byte stream (valid/data/error) with source and sink views
interface gmii_if;
  logic       valid;
  logic [7:0] data;
  logic       error;
  modport master (output valid, data, error);
  modport slave  (input valid, data, error);
endinterface

// File: rtl/crc32_d8.sv
// crc32_d8: combinational reflected CRC-32 update by one byte, LSB first
module crc32_d8
  import crc32_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);
  always_comb begin
    crc_next = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++)
      crc_next = crc_next[0] ? (crc_next >> 1) ^ CRC32_POLY_REFL : crc_next >> 1;
  end
endmodule

// File: rtl/rx_crc_checker.sv
// rx_crc_checker: strips preamble/SFD, checks CRC-32 residue, pulses a verdict 1 clk after frame end; RX_CRC_STATS_EN adds good/bad frame counters
module rx_crc_checker
  import crc32_pkg::*;
#(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int LEN_W           = 11
) (
  input  logic             clk,
  input  logic             rst,
  gmii_if.slave            gmii_rx_if_i,
  output logic             crc_error_o,
  output logic             crc_ok_o,
  output logic             runt_o,
  output logic [LEN_W-1:0] frame_len_o
`ifdef RX_CRC_STATS_EN
  ,
  output logic [31:0]      good_cnt_o,
  output logic [31:0]      bad_cnt_o
`endif
);
  crc_chk_state_t state, state_n;
  logic [31:0] crc, crc_next;
  logic [LEN_W-1:0] cnt;
  logic valid, fresh, load, absorb, finish, unused_err;
  logic [7:0] data;
  assign valid = gmii_rx_if_i.valid;
  assign data = gmii_rx_if_i.data;
  assign unused_err = gmii_rx_if_i.error;
  crc32_d8 u_crc (.crc(crc), .data(data), .crc_next(crc_next));
  // fresh marks the first clock after reset so a frame already in flight is dropped
  always_comb begin
    state_n = state;
    finish = 1'b0;
    case (state)
      IDLE: if (valid) state_n = fresh ? DROP : data == PREAMBLE_BYTE ? PREAMBLE : data == SFD_BYTE ? DATA : DROP;
      PREAMBLE: state_n = !valid ? IDLE : data == PREAMBLE_BYTE ? PREAMBLE : data == SFD_BYTE ? DATA : DROP;
      DATA: if (!valid) begin
        state_n = IDLE;
        finish = 1'b1;
      end
      DROP: if (!valid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign load = state_n == DATA && state != DATA;
  assign absorb = state == DATA && valid;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      fresh <= 1'b1;
    end else begin
      state <= state_n;
      fresh <= 1'b0;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      crc <= CRC32_INIT;
      cnt <= '0;
    end else if (load) begin
      crc <= CRC32_INIT;
      cnt <= '0;
    end else if (absorb) begin
      crc <= crc_next;
      cnt <= &cnt ? cnt : cnt + 1'b1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      crc_ok_o <= 1'b0;
      crc_error_o <= 1'b0;
      runt_o <= 1'b0;
      frame_len_o <= '0;
    end else begin
      crc_ok_o <= finish && crc == CRC32_RESIDUE;
      crc_error_o <= finish && crc != CRC32_RESIDUE;
      runt_o <= finish && cnt < LEN_W'(MIN_FRAME_BYTES);
      if (finish) frame_len_o <= cnt;
    end
`ifdef RX_CRC_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      good_cnt_o <= '0;
      bad_cnt_o <= '0;
    end else begin
      good_cnt_o <= good_cnt_o + {31'd0, crc_ok_o};
      bad_cnt_o <= bad_cnt_o + {31'd0, crc_error_o};
    end
`endif
endmodule

// File: tb/tb_rx_crc_checker.sv
// tb_rx_crc_checker: randomized frames checked every cycle against a frame-level CRC model
module tb_rx_crc_checker;
  import crc32_pkg::*;
  typedef struct {bit ok; int len;} ver_t;
  logic clk = 0, rst = 1;
  int cyc = 0, errors = 0, checks = 0, n_ok = 0, n_bad = 0;
  ver_t exp_q[int];
  ver_t ce;
  bit ch;
  logic ok64, err64, runt64, ok13, err13, runt13;
  logic [10:0] len64, len13;
`ifdef RX_CRC_STATS_EN
  logic [31:0] g64, b64, g13, b13;
`endif
  gmii_if gi();
  rx_crc_checker dut (
    .clk(clk), .rst(rst), .gmii_rx_if_i(gi),
    .crc_error_o(err64), .crc_ok_o(ok64), .runt_o(runt64), .frame_len_o(len64)
`ifdef RX_CRC_STATS_EN
    , .good_cnt_o(g64), .bad_cnt_o(b64)
`endif
  );
  rx_crc_checker #(.MIN_FRAME_BYTES(13)) dut13 (
    .clk(clk), .rst(rst), .gmii_rx_if_i(gi),
    .crc_error_o(err13), .crc_ok_o(ok13), .runt_o(runt13), .frame_len_o(len13)
`ifdef RX_CRC_STATS_EN
    , .good_cnt_o(g13), .bad_cnt_o(b13)
`endif
  );
  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  // standard CRC-32 of the first n bytes, bit-serial, with final inversion
  function automatic logic [31:0] crc32_ref(input logic [7:0] b[$], input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 8; k++) begin
        logic fb;
        fb = c[0] ^ b[i][k];
        c = c >> 1;
        if (fb) c ^= 32'hEDB88320;
      end
    return ~c;
  endfunction

  // a frame is good when its last four bytes are the little-endian CRC of the rest
  function automatic bit model_ok(input logic [7:0] b[$]);
    int n = b.size();
    if (n < 4) return 0;
    return crc32_ref(b, n - 4) == {b[n-1], b[n-2], b[n-3], b[n-4]};
  endfunction

  function automatic logic [31:0] sat(input int n);
    return 32'(n > 2047 ? 2047 : n);
  endfunction

  task automatic drive(input logic v, input logic [7:0] d);
    @(posedge clk);
    #1;
    gi.valid = v;
    gi.data = v ? d : 8'h00;
    gi.error = v && $urandom_range(0, 15) == 0;
  endtask

  task automatic send_frame(input logic [7:0] body[$], input int npre);
    ver_t e;
    for (int i = 0; i < npre; i++) drive(1, 8'h55);
    drive(1, 8'hD5);
    foreach (body[i]) drive(1, body[i]);
    drive(0, 8'h00);
    e.ok = model_ok(body);
    e.len = body.size();
    exp_q[cyc + 1] = e;
    if (e.ok) n_ok++;
    else n_bad++;
  endtask

  task automatic add_fcs(inout logic [7:0] b[$]);
    logic [31:0] c;
    c = crc32_ref(b, b.size());
    for (int i = 0; i < 4; i++) b.push_back(c[8*i +: 8]);
  endtask

  always @(negedge clk)
    if (cyc > 1) begin
      ch = exp_q.exists(cyc);
      ce = ch ? exp_q[cyc] : '{ok: 0, len: 0};
      chk("ok64", 32'(ok64), 32'(ch && ce.ok));
      chk("err64", 32'(err64), 32'(ch && !ce.ok));
      chk("runt64", 32'(runt64), 32'(ch && ce.len < 64));
      chk("ok13", 32'(ok13), 32'(ch && ce.ok));
      chk("err13", 32'(err13), 32'(ch && !ce.ok));
      chk("runt13", 32'(runt13), 32'(ch && ce.len < 13));
      if (ch) begin
        chk("len64", 32'(len64), sat(ce.len));
        chk("len13", 32'(len13), sat(ce.len));
      end
    end

  initial begin
    logic [7:0] good[$], bad[$], body[$], raw[$];
    gi.valid = 0;
    gi.data = 0;
    gi.error = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ok", 32'(ok64), 0);
    chk("rst_err", 32'(err64), 0);
    chk("rst_len", 32'(len64), 0);
`ifdef RX_CRC_STATS_EN
    chk("rst_good_cnt", g64, 0);
`endif
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 9; i++) good.push_back(8'(8'h31 + i));
    chk("pin_check9", crc32_ref(good, 9), 32'hCBF43926);
    good.push_back(8'h26); good.push_back(8'h39); good.push_back(8'hF4); good.push_back(8'hCB);
    bad = good;
    bad[12] = 8'hCA;
    chk("pin_good", 32'(model_ok(good)), 1);
    chk("pin_bad", 32'(model_ok(bad)), 0);
    send_frame(good, 7);
    @(negedge clk); @(negedge clk);
    chk("good_ok13", 32'(ok13), 1);
    chk("good_runt13", 32'(runt13), 0);
    chk("good_len13", 32'(len13), 13);
    chk("good_runt64", 32'(runt64), 1);
    chk("good_ok64", 32'(ok64), 1);
    send_frame(bad, 7);
    @(negedge clk); @(negedge clk);
    chk("bad_err13", 32'(err13), 1);
    chk("bad_ok13", 32'(ok13), 0);
    raw = '{8'h55, 8'h55, 8'h12, 8'hD5, 8'h31, 8'h32, 8'h00, 8'hFF};
    foreach (raw[i]) drive(1, raw[i]);
    drive(0, 0);
    raw = '{8'hAA, 8'hD5, 8'h55};
    foreach (raw[i]) drive(1, raw[i]);
    drive(0, 0);
    body.delete();
    send_frame(body, 3);
    @(negedge clk); @(negedge clk);
    chk("empty_err", 32'(err64), 1);
    chk("empty_runt", 32'(runt64), 1);
    chk("empty_len", 32'(len64), 0);
    send_frame(good, 7);
    send_frame(good, 0);
    drive(0, 0);
    for (int i = 0; i < 7; i++) drive(1, 8'h55);
    drive(1, 8'hD5);
    for (int i = 0; i < 20; i++) drive(1, 8'($urandom));
    #1 rst = 1;
    n_ok = 0;
    n_bad = 0;
    drive(1, 8'($urandom));
    drive(1, 8'($urandom));
    rst = 0;
    for (int i = 0; i < 10; i++) drive(1, 8'($urandom));
    drive(0, 0);
    send_frame(good, 7);
    @(negedge clk); @(negedge clk);
    chk("post_rst_ok", 32'(ok64), 1);
    repeat (40) begin
      repeat ($urandom_range(0, 3)) drive(0, 0);
      body.delete();
      if ($urandom_range(0, 9) != 0) begin
        repeat ($urandom_range(0, 80)) body.push_back(8'($urandom));
        add_fcs(body);
        if ($urandom_range(0, 1) != 0) body[$urandom_range(0, body.size() - 1)] ^= 8'(1 << $urandom_range(0, 7));
      end
      send_frame(body, $urandom_range(0, 7));
    end
    body.delete();
    repeat (2100) body.push_back(8'($urandom));
    add_fcs(body);
    send_frame(body, 7);
    @(negedge clk); @(negedge clk);
    chk("sat_len", 32'(len64), 2047);
    repeat (4) drive(0, 0);
`ifdef RX_CRC_STATS_EN
    chk("good_cnt", g64, 32'(n_ok));
    chk("bad_cnt", b64, 32'(n_bad));
    chk("good_cnt13", g13, 32'(n_ok));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
